// File: rtl/gx_rst_pkg.sv
// Shared state encodings and default timing for the GX bank reset sequencer.
package gx_rst_pkg;

  typedef enum logic [1:0] {TX_RST, TX_ANA, TX_DIG, TX_RDY} tx_state_t;
  typedef enum logic [1:0] {RX_RST, RX_ANA, RX_LTD, RX_RDY} rx_state_t;

  localparam int unsigned NChDefault     = 6;
  localparam int unsigned TTxAnaDefault  = 10;
  localparam int unsigned TTxDigDefault  = 10;
  localparam int unsigned TRxAnaDefault  = 10;
  localparam int unsigned TLtdDefault    = 5000;

  function automatic int unsigned max_of4(input int unsigned a, input int unsigned b,
                                          input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/gx_chan_rst_fsm.sv
// One channel's TX and RX reset sequencers; all status inputs arrive already synchronised.
module gx_chan_rst_fsm
  import gx_rst_pkg::*;
#(
  parameter int unsigned T_TX_ANA = TTxAnaDefault,
  parameter int unsigned T_TX_DIG = TTxDigDefault,
  parameter int unsigned T_RX_ANA = TRxAnaDefault,
  parameter int unsigned T_LTD    = TLtdDefault
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tx_rst_req_i,
  input  logic rx_rst_req_i,
  input  logic pll_locked_i,
  input  logic tx_cal_busy_i,
  input  logic rx_cal_busy_i,
  input  logic rx_ltd_i,
  output logic tx_analogreset_o,
  output logic tx_digitalreset_o,
  output logic rx_analogreset_o,
  output logic rx_digitalreset_o,
  output logic tx_ready_o,
  output logic rx_ready_o
);

  localparam int unsigned CntW = $clog2(max_of4(T_TX_ANA, T_TX_DIG, T_RX_ANA, T_LTD) + 1);

  localparam logic [CntW-1:0] TxAnaLast = CntW'(T_TX_ANA - 1);
  localparam logic [CntW-1:0] TxDigLast = CntW'(T_TX_DIG - 1);
  localparam logic [CntW-1:0] RxAnaLast = CntW'(T_RX_ANA - 1);
  localparam logic [CntW-1:0] LtdLast   = CntW'(T_LTD - 1);

  function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] v);
    return (v == '1) ? v : v + CntW'(1);
  endfunction

  tx_state_t       tx_state_q, tx_state_d;
  rx_state_t       rx_state_q, rx_state_d;
  logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
  logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
  logic            tx_ana_q, tx_dig_q, tx_rdy_q;
  logic            rx_ana_q, rx_dig_q, rx_rdy_q;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    unique case (tx_state_q)
      TX_RST: begin
        if (!tx_rst_req_i && pll_locked_i && !tx_cal_busy_i) begin
          tx_state_d = TX_ANA;
          tx_cnt_d   = '0;
        end
      end
      TX_ANA: begin
        if (tx_cal_busy_i) begin
          tx_cnt_d = '0;
        end else if (tx_cnt_q == TxAnaLast) begin
          tx_state_d = TX_DIG;
          tx_cnt_d   = '0;
        end else begin
          tx_cnt_d = sat_inc(tx_cnt_q);
        end
      end
      TX_DIG: begin
        if (tx_cnt_q == TxDigLast) begin
          tx_state_d = TX_RDY;
          tx_cnt_d   = '0;
        end else begin
          tx_cnt_d = sat_inc(tx_cnt_q);
        end
      end
      TX_RDY: ;
      default: tx_state_d = TX_RST;
    endcase
    // Request or PLL loss beats any count expiry in the same cycle.
    if (tx_rst_req_i || !pll_locked_i) begin
      tx_state_d = TX_RST;
      tx_cnt_d   = '0;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    unique case (rx_state_q)
      RX_RST: begin
        if (!rx_cal_busy_i) begin
          rx_state_d = RX_ANA;
          rx_cnt_d   = '0;
        end
      end
      RX_ANA: begin
        if (rx_cal_busy_i) begin
          rx_cnt_d = '0;
        end else if (rx_cnt_q == RxAnaLast) begin
          rx_state_d = RX_LTD;
          rx_cnt_d   = '0;
        end else begin
          rx_cnt_d = sat_inc(rx_cnt_q);
        end
      end
      RX_LTD: begin
        if (!rx_ltd_i) begin
          rx_cnt_d = '0;
        end else if (rx_cnt_q == LtdLast) begin
          rx_state_d = RX_RDY;
          rx_cnt_d   = '0;
        end else begin
          rx_cnt_d = sat_inc(rx_cnt_q);
        end
      end
      RX_RDY: begin
        // Lock loss only re-asserts the digital reset; analog stays released.
        if (!rx_ltd_i) begin
          rx_state_d = RX_LTD;
          rx_cnt_d   = '0;
        end
      end
      default: rx_state_d = RX_RST;
    endcase
    if (rx_rst_req_i) begin
      rx_state_d = RX_RST;
      rx_cnt_d   = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_state_q <= TX_RST;
      tx_cnt_q   <= '0;
      tx_ana_q   <= 1'b1;
      tx_dig_q   <= 1'b1;
      tx_rdy_q   <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_ana_q   <= (tx_state_d == TX_RST) || (tx_state_d == TX_ANA);
      tx_dig_q   <= (tx_state_d != TX_RDY);
      tx_rdy_q   <= (tx_state_d == TX_RDY);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_state_q <= RX_RST;
      rx_cnt_q   <= '0;
      rx_ana_q   <= 1'b1;
      rx_dig_q   <= 1'b1;
      rx_rdy_q   <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_ana_q   <= (rx_state_d == RX_RST) || (rx_state_d == RX_ANA);
      rx_dig_q   <= (rx_state_d != RX_RDY);
      rx_rdy_q   <= (rx_state_d == RX_RDY);
    end
  end

  assign tx_analogreset_o  = tx_ana_q;
  assign tx_digitalreset_o = tx_dig_q;
  assign tx_ready_o        = tx_rdy_q;
  assign rx_analogreset_o  = rx_ana_q;
  assign rx_digitalreset_o = rx_dig_q;
  assign rx_ready_o        = rx_rdy_q;

endmodule

// File: rtl/gx_x6_rst_ctrl.sv
// Reset controller for the 6-channel GX bank: status synchronisers plus one sequencer per lane.
module gx_x6_rst_ctrl
  import gx_rst_pkg::*;
#(
  parameter int unsigned N_CH     = NChDefault,
  parameter int unsigned T_TX_ANA = TTxAnaDefault,
  parameter int unsigned T_TX_DIG = TTxDigDefault,
  parameter int unsigned T_RX_ANA = TRxAnaDefault,
  parameter int unsigned T_LTD    = TLtdDefault
) (
  input  logic            reconfig_clk,
  input  logic            reconfig_reset_n,
  input  logic            tx_pll_locked,
  input  logic [N_CH-1:0] tx_rst_req,
  input  logic [N_CH-1:0] rx_rst_req,
  input  logic [N_CH-1:0] tx_cal_busy,
  input  logic [N_CH-1:0] rx_cal_busy,
  input  logic [N_CH-1:0] rx_is_lockedtodata,
  output logic [N_CH-1:0] tx_analogreset,
  output logic [N_CH-1:0] tx_digitalreset,
  output logic [N_CH-1:0] rx_analogreset,
  output logic [N_CH-1:0] rx_digitalreset,
  output logic [N_CH-1:0] tx_ready,
  output logic [N_CH-1:0] rx_ready
);

  localparam int unsigned SyncW = 3 * N_CH + 1;

  logic [SyncW-1:0] sync_raw, sync_q1, sync_q2;
  logic             pll_s;
  logic [N_CH-1:0]  tx_cal_busy_s, rx_cal_busy_s, ltd_s;

  assign sync_raw = {rx_is_lockedtodata, rx_cal_busy, tx_cal_busy, tx_pll_locked};

  // Single PLL synchroniser shared by all lanes.
  always_ff @(posedge reconfig_clk or negedge reconfig_reset_n) begin
    if (!reconfig_reset_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= sync_raw;
      sync_q2 <= sync_q1;
    end
  end

  assign pll_s         = sync_q2[0];
  assign tx_cal_busy_s = sync_q2[N_CH:1];
  assign rx_cal_busy_s = sync_q2[2*N_CH:N_CH+1];
  assign ltd_s         = sync_q2[3*N_CH:2*N_CH+1];

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    gx_chan_rst_fsm #(
      .T_TX_ANA (T_TX_ANA),
      .T_TX_DIG (T_TX_DIG),
      .T_RX_ANA (T_RX_ANA),
      .T_LTD    (T_LTD)
    ) u_fsm (
      .clk_i             (reconfig_clk),
      .rst_ni            (reconfig_reset_n),
      .tx_rst_req_i      (tx_rst_req[i]),
      .rx_rst_req_i      (rx_rst_req[i]),
      .pll_locked_i      (pll_s),
      .tx_cal_busy_i     (tx_cal_busy_s[i]),
      .rx_cal_busy_i     (rx_cal_busy_s[i]),
      .rx_ltd_i          (ltd_s[i]),
      .tx_analogreset_o  (tx_analogreset[i]),
      .tx_digitalreset_o (tx_digitalreset[i]),
      .rx_analogreset_o  (rx_analogreset[i]),
      .rx_digitalreset_o (rx_digitalreset[i]),
      .tx_ready_o        (tx_ready[i]),
      .rx_ready_o        (rx_ready[i])
    );
  end

endmodule
